// File: rtl/mode_switch_sequencer_pkg.sv
// Shared mode codes, sequencer state encoding and counter sizing helper
// for the video mode-switch sequencer.
package mode_switch_sequencer_pkg;

  localparam logic [7:0] MODE_480I  = 8'h01;
  localparam logic [7:0] MODE_720P  = 8'h02;
  localparam logic [7:0] MODE_1080P = 8'h03;

  typedef enum logic [2:0] {
    MSS_IDLE      = 3'd0,
    MSS_SETTLE    = 3'd1,
    MSS_BLANK     = 3'd2,
    MSS_RECONF    = 3'd3,
    MSS_WAIT_ACK  = 3'd4,
    MSS_WAIT_LOCK = 3'd5,
    MSS_FAULT     = 3'd6
  } mss_state_e;

  // Width able to hold 0..n; never below one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mode_switch_sequencer_stability.sv
// config_stability_counter: tracks the requested mode while settling and
// reports when it has been unchanged for SETTLE_CYCLES consecutive cycles.
module config_stability_counter
  import mode_switch_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] config_data,
  input  logic       config_changed,
  output logic       stable,
  output logic [7:0] target
);

  localparam int CW = cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    target_q, target_d;
  logic          change;

  always_comb begin
    change   = config_changed || (config_data != target_q);
    target_d = target_q;
    cnt_d    = '0;
    if (enable) begin
      target_d = config_data;
      if (change) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      target_q <= MODE_480I;
    end else begin
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  assign stable = enable && !change && (cnt_q == CNT_LAST);
  assign target = target_q;

endmodule

// File: rtl/mode_switch_sequencer.sv
// Video mode-change sequencer: debounce, blank, PLL reconfig, wait for lock, unblank.
// Optional lock timeout with retries and FAULT state: define MODE_SWITCH_TIMEOUT_EN.
module mode_switch_sequencer
  import mode_switch_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024,
  parameter int BLANK_CYCLES  = 16
`ifdef MODE_SWITCH_TIMEOUT_EN
  ,
  parameter int LOCK_TIMEOUT  = 1048576,
  parameter int MAX_RETRIES   = 3
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] config_data,
  input  logic       config_changed,
  input  logic       pll_reconfig_busy,
  input  logic       pll_locked,
  output logic       pll_reconfig_start,
  output logic [7:0] pll_reconfig_mode,
  output logic [7:0] active_mode,
  output logic       video_enable,
  output logic       busy,
  output logic       error,
  output logic [2:0] dbg_state
);

  localparam int BW = cnt_width(BLANK_CYCLES);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  mss_state_e state_q, state_d;
  logic [7:0] active_q, active_d;
  logic [7:0] reconf_mode_q, reconf_mode_d;
  logic       video_q, video_d;
  logic       start_q, start_d;
  logic       configured_q, configured_d;
  logic       pending_q, pending_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  logic       stable;
  logic [7:0] target;
  logic       change;
  logic       lock_ok;

`ifdef MODE_SWITCH_TIMEOUT_EN
  localparam int TW = cnt_width(LOCK_TIMEOUT);
  localparam int RW = cnt_width(MAX_RETRIES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          error_q, error_d;
`endif

  config_stability_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_stability (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (state_q == MSS_SETTLE),
    .config_data   (config_data),
    .config_changed(config_changed),
    .stable        (stable),
    .target        (target)
  );

  assign change  = config_changed || (config_data != target);
  assign lock_ok = !pll_reconfig_busy && pll_locked;

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    reconf_mode_d = reconf_mode_q;
    video_d       = video_q;
    configured_d  = configured_q;
    pending_d     = pending_q;
    blank_cnt_d   = '0;
`ifdef MODE_SWITCH_TIMEOUT_EN
    timer_d       = '0;
    retry_d       = retry_q;
    error_d       = error_q;
`endif
    case (state_q)
      MSS_IDLE: begin
        if (config_changed || (config_data != active_q)) state_d = MSS_SETTLE;
      end
      MSS_SETTLE: begin
        if (stable) begin
          state_d = (configured_q && (target == active_q)) ? MSS_IDLE : MSS_BLANK;
        end
      end
      MSS_BLANK: begin
        if (change) begin
          state_d = MSS_SETTLE;
        end else if (blank_cnt_q == BLANK_LAST) begin
          state_d = MSS_RECONF;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      MSS_RECONF: begin
        state_d = MSS_WAIT_ACK;
      end
      MSS_WAIT_ACK: begin
        if (change) pending_d = 1'b1;
        if (pll_reconfig_busy) state_d = MSS_WAIT_LOCK;
      end
      MSS_WAIT_LOCK: begin
        if (change) pending_d = 1'b1;
        if (lock_ok) begin
          active_d     = target;
          configured_d = 1'b1;
`ifdef MODE_SWITCH_TIMEOUT_EN
          retry_d      = '0;
`endif
          // A change seen in the lock cycle itself still takes the pending path.
          if (pending_q || change) begin
            state_d   = MSS_SETTLE;
            pending_d = 1'b0;
            video_d   = 1'b0;
          end else begin
            state_d = MSS_IDLE;
          end
        end
      end
      MSS_FAULT: begin
        if (config_changed) begin
          state_d = MSS_SETTLE;
`ifdef MODE_SWITCH_TIMEOUT_EN
          error_d = 1'b0;
          retry_d = '0;
`endif
        end
      end
      default: state_d = MSS_SETTLE;
    endcase

`ifdef MODE_SWITCH_TIMEOUT_EN
    // Timer spans both wait states; a lock in the final cycle beats the timeout.
    if ((state_q == MSS_WAIT_ACK) || (state_q == MSS_WAIT_LOCK)) begin
      if ((state_d == MSS_IDLE) || (state_d == MSS_SETTLE)) begin
        timer_d = '0;
      end else if (timer_q == TIMER_LAST) begin
        timer_d = '0;
        if (retry_q == RETRY_MAX) begin
          state_d = MSS_FAULT;
          error_d = 1'b1;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = MSS_RECONF;
        end
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
`endif

    if (state_d == MSS_RECONF) reconf_mode_d = target;
    if ((state_d == MSS_BLANK) || (state_d == MSS_FAULT)) video_d = 1'b0;
    if (state_d == MSS_IDLE) video_d = 1'b1;
    start_d = (state_d == MSS_RECONF);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= MSS_SETTLE;
      active_q      <= MODE_480I;
      reconf_mode_q <= MODE_480I;
      video_q       <= 1'b0;
      start_q       <= 1'b0;
      configured_q  <= 1'b0;
      pending_q     <= 1'b0;
      blank_cnt_q   <= '0;
`ifdef MODE_SWITCH_TIMEOUT_EN
      timer_q       <= '0;
      retry_q       <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      reconf_mode_q <= reconf_mode_d;
      video_q       <= video_d;
      start_q       <= start_d;
      configured_q  <= configured_d;
      pending_q     <= pending_d;
      blank_cnt_q   <= blank_cnt_d;
`ifdef MODE_SWITCH_TIMEOUT_EN
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      error_q       <= error_d;
`endif
    end
  end

  assign pll_reconfig_start = start_q;
  assign pll_reconfig_mode  = reconf_mode_q;
  assign active_mode        = active_q;
  assign video_enable       = video_q;
  assign busy               = (state_q != MSS_IDLE) && (state_q != MSS_FAULT);
  assign dbg_state          = state_q;
`ifdef MODE_SWITCH_TIMEOUT_EN
  assign error              = error_q;
`else
  assign error              = 1'b0;
`endif

endmodule

// File: tb/tb_mode_switch_sequencer.sv
// Bench for mode_switch_sequencer: randomized PLL model, expected start-pulse
// queue drained by a monitor, and directed mode-change scenarios.
module tb_mode_switch_sequencer;
  import mode_switch_sequencer_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] config_data;
  logic       config_changed;
  logic       pll_reconfig_busy;
  logic       pll_locked;
  logic       pll_reconfig_start;
  logic [7:0] pll_reconfig_mode;
  logic [7:0] active_mode;
  logic       video_enable;
  logic       busy;
  logic       error;
  logic [2:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int lock_cyc = 0;
  bit lock_allow = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] exp_video_mode = MODE_720P;
  logic [7:0] model_active = MODE_480I;

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mode_switch_sequencer #(
    .SETTLE_CYCLES(8),
    .BLANK_CYCLES (4)
`ifdef MODE_SWITCH_TIMEOUT_EN
    ,
    .LOCK_TIMEOUT (32),
    .MAX_RETRIES  (1)
`endif
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .config_data       (config_data),
    .config_changed    (config_changed),
    .pll_reconfig_busy (pll_reconfig_busy),
    .pll_locked        (pll_locked),
    .pll_reconfig_start(pll_reconfig_start),
    .pll_reconfig_mode (pll_reconfig_mode),
    .active_mode       (active_mode),
    .video_enable      (video_enable),
    .busy              (busy),
    .error             (error),
    .dbg_state         (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [7:0] next_mode(input logic [7:0] m);
    case (m)
      MODE_480I: return MODE_720P;
      MODE_720P: return MODE_1080P;
      default:   return MODE_480I;
    endcase
  endfunction

  function automatic logic [7:0] pick_mode();
    case ($urandom_range(0, 2))
      0:       return MODE_480I;
      1:       return MODE_720P;
      default: return MODE_1080P;
    endcase
  endfunction

  function automatic logic [7:0] probe(input int sel);
    case (sel)
      0:       return {7'd0, video_enable};
      1:       return {7'd0, pll_reconfig_busy};
      2:       return active_mode;
      default: return {7'd0, busy};
    endcase
  endfunction

  // Bounded wait for a signal to reach a value; an expired bound is a miscompare.
  task automatic wait_for(input string name, input int sel, input logic [7:0] val);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (probe(sel) == val) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: still %0h after 400 cycles, expected %0h", name, probe(sel), val);
    end
  endtask

  task automatic wait_idle(input string name);
    tick();
    wait_for(name, 3, 8'd0);
  endtask

  task automatic wait_start(input string name, output int t);
    bit ok;
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (pll_reconfig_start) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: no start pulse within 400 cycles, expected one", name);
    end
  endtask

  // driver: request a mode with a one-cycle change strobe
  task automatic request(input logic [7:0] m);
    config_data    = m;
    config_changed = 1'b1;
    tick();
    config_changed = 1'b0;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_state"},       32'(dbg_state), 32'(MSS_SETTLE));
    check({pfx, "_active"},      32'(active_mode), 32'(MODE_480I));
    check({pfx, "_reconf_mode"}, 32'(pll_reconfig_mode), 32'(MODE_480I));
    check({pfx, "_video"},       32'(video_enable), 32'd0);
    check({pfx, "_start"},       32'(pll_reconfig_start), 32'd0);
    check({pfx, "_busy"},        32'(busy), 32'd1);
    check({pfx, "_error"},       32'(error), 32'd0);
  endtask

  // PLL reconfig block model: busy 2..10 cycles after start, then lock.
  initial begin : pll_model
    int ph;
    int cnt;
    ph = 0;
    cnt = 0;
    pll_reconfig_busy = 1'b0;
    pll_locked = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (!reset_n) begin
        ph = 0;
        pll_reconfig_busy = 1'b0;
        pll_locked = 1'b0;
      end else if (pll_reconfig_start) begin
        ph = 1;
        cnt = $urandom_range(2, 10) - 1;
        pll_reconfig_busy = 1'b0;
        pll_locked = 1'b0;
      end else if (ph != 0) begin
        if (cnt > 0) begin
          cnt--;
        end else begin
          case (ph)
            1: begin pll_reconfig_busy = 1'b1; cnt = $urandom_range(1, 6); ph = 2; end
            2: begin pll_reconfig_busy = 1'b0; cnt = $urandom_range(1, 4); ph = 3; end
            default: begin
              if (lock_allow) begin
                pll_locked = 1'b1;
                lock_cyc = cyc;
              end
              ph = 0;
            end
          endcase
        end
      end
    end
  end

  // scoreboard monitor: each start pulse pops one expected mode
  initial begin : monitor
    logic prev_video;
    prev_video = 1'b0;
    forever begin
      @(negedge clock);
      if (pll_reconfig_start) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL start_unexpected: got start with mode %0h, expected no start", pll_reconfig_mode);
        end else begin
          check("start_mode", 32'(pll_reconfig_mode), 32'(exp_q.pop_front()));
        end
      end
      if (video_enable && !prev_video)
        check("video_rise_active_mode", 32'(active_mode), 32'(exp_video_mode));
      prev_video = video_enable;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit dropped;
    int starts;
    int t1;
    int t2;
    logic [7:0] m;

    reset_n = 1'b0;
    config_data = MODE_720P;
    config_changed = 1'b0;
    tick(3);

    // 1: power-up sequence to 720p
    check_reset("t1_reset");
    exp_q.push_back(MODE_720P);
    exp_video_mode = MODE_720P;
    model_active = MODE_720P;
    reset_n = 1'b1;
    wait_for("t1_video_up", 0, 8'd1);
    check("t1_video_one_cycle_after_lock", 32'(cyc - lock_cyc), 32'd1);
    check("t1_active", 32'(active_mode), 32'(MODE_720P));
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: three-cycle glitch to 1080p then back to 720p
    dropped = 1'b0;
    starts = 0;
    config_data = MODE_1080P;
    config_changed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      config_changed = 1'b0;
      if (!video_enable) dropped = 1'b1;
    end
    config_data = MODE_720P;
    config_changed = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      config_changed = 1'b0;
      if (!video_enable) dropped = 1'b1;
      if (pll_reconfig_start) starts++;
    end
    check("t2_video_never_dropped", 32'(dropped), 32'd0);
    check("t2_no_start", 32'(starts), 32'd0);
    check("t2_idle", 32'(busy), 32'd0);
    check("t2_active", 32'(active_mode), 32'(MODE_720P));

    // 3: change to 1080p in the 2nd BLANK cycle of a 480i switch
    request(MODE_480I);
    wait_for("t3_blank_entry", 0, 8'd0);
    tick();
    config_data = MODE_1080P;
    config_changed = 1'b1;
    exp_q.push_back(MODE_1080P);
    exp_video_mode = MODE_1080P;
    tick();
    config_changed = 1'b0;
    check("t3_video_held_low", 32'(video_enable), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);

    // 4: change to 480i while waiting for lock on 1080p
    wait_for("t4_pll_busy", 1, 8'd1);
    config_data = MODE_480I;
    config_changed = 1'b1;
    exp_q.push_back(MODE_480I);
    exp_video_mode = MODE_480I;
    model_active = MODE_480I;
    tick();
    config_changed = 1'b0;
    wait_for("t4_first_done", 2, MODE_1080P);
    check("t4_video_low_after_first", 32'(video_enable), 32'd0);
    wait_idle("t4_idle");
    check("t4_active", 32'(active_mode), 32'(MODE_480I));
    check("t4_reconf_mode", 32'(pll_reconfig_mode), 32'(MODE_480I));
    check("t4_video", 32'(video_enable), 32'd1);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // randomized mode requests against the reference model
    for (int i = 0; i < 12; i++) begin
      m = pick_mode();
      tick($urandom_range(0, 5));
      if (m != model_active) exp_q.push_back(m);
      exp_video_mode = m;
      model_active = m;
      request(m);
      wait_idle("rnd_idle");
      check("rnd_active", 32'(active_mode), 32'(m));
      check("rnd_video", 32'(video_enable), 32'd1);
      check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
    end

`ifdef MODE_SWITCH_TIMEOUT_EN
    // 5: PLL never locks -> retry, then FAULT; a change strobe recovers
    m = next_mode(model_active);
    lock_allow = 1'b0;
    exp_q.push_back(m);
    exp_q.push_back(m);
    request(m);
    wait_start("t5_first_start", t1);
    wait_start("t5_retry_start", t2);
    check("t5_retry_gap_ge_32", 32'((t2 - t1) >= 32), 32'd1);
    wait_for("t5_fault", 3, 8'd0);
    check("t5_error", 32'(error), 32'd1);
    check("t5_video", 32'(video_enable), 32'd0);
    lock_allow = 1'b1;
    exp_q.push_back(m);
    exp_video_mode = m;
    model_active = m;
    config_changed = 1'b1;
    tick();
    config_changed = 1'b0;
    check("t5_error_cleared", 32'(error), 32'd0);
    check("t5_busy_again", 32'(busy), 32'd1);
    wait_idle("t5_idle");
    check("t5_active", 32'(active_mode), 32'(m));
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

    // 6: one-cycle reset in WAIT_ACK
    m = next_mode(model_active);
    exp_q.push_back(m);
    request(m);
    wait_start("t6_start", t1);
    tick();
    reset_n = 1'b0;
    tick();
    check_reset("t6_reset");
    exp_q.push_back(m);
    exp_video_mode = m;
    model_active = m;
    reset_n = 1'b1;
    wait_idle("t6_idle");
    check("t6_active", 32'(active_mode), 32'(m));
    check("t6_video", 32'(video_enable), 32'd1);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
